mem_copy_engine: RTL and testbench

- Bus initiator (DMA-style) that drives the byte-wide memory's address, writeData and writeEnable, and consumes its combinational readData.
- Copies a block of bytes from a source to a destination region on command.
- Sits beside the CPU datapath and shares the memory port through an external mux selected by busy.
- Forward copy only: ascending addresses, one byte per two clock cycles.

---
 rtl/mem_copy_engine_pkg.sv | 15 +
 rtl/mem_copy_engine_if.sv | 27 ++
 rtl/mem_copy_engine.sv | 91 +++++++++
 tb/tb_mem_copy_engine.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_copy_engine_pkg.sv
// Shared types and widths for the block-copy engine.
// Imported by the engine and its memory-bus interface.
package mem_copy_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } copy_state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Byte-wide memory port driven by the copy engine; memory answers reads combinationally.
// The engine takes the master side, the memory (or bus mux) the slave side.
interface mem_copy_engine_if #(
  parameter int ADDR_WIDTH = mem_copy_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = mem_copy_pkg::DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] memAddress;
  logic [DATA_WIDTH-1:0] memWriteData;
  logic                  memWriteEnable;
  logic [DATA_WIDTH-1:0] memReadData;

  modport master (
    output memAddress,
    output memWriteData,
    output memWriteEnable,
    input  memReadData
  );

  modport slave (
    input  memAddress,
    input  memWriteData,
    input  memWriteEnable,
    output memReadData
  );

endinterface

// File: rtl/mem_copy_engine.sv
// Forward block copy: one byte read then written every two cycles, ascending, wrapping addresses.
// Commands are accepted only in IDLE; start elsewhere is dropped without re-latching operands.
module mem_copy_engine #(
  parameter int ADDR_WIDTH = mem_copy_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = mem_copy_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] srcAddr,
  input  logic [ADDR_WIDTH-1:0] dstAddr,
  input  logic [ADDR_WIDTH-1:0] length,
  mem_copy_engine_if.master     mem,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bytesCopied
);

  import mem_copy_pkg::*;

  copy_state_t           state;
  copy_state_t           state_nxt;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_byte;

  // Counter wraps with the same width as length, so length=all-ones still terminates.
  assign last_byte = ((bytesCopied + ADDR_WIDTH'(1)) == len_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      data_q      <= '0;
      bytesCopied <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            src_q       <= srcAddr;
            dst_q       <= dstAddr;
            len_q       <= length;
            bytesCopied <= '0;
          end
        end
        READ:    data_q      <= mem.memReadData;
        WRITE:   bytesCopied <= bytesCopied + ADDR_WIDTH'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt          = state;
    mem.memAddress     = '0;
    mem.memWriteData   = '0;
    mem.memWriteEnable = 1'b0;
    busy               = 1'b0;
    done               = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (length != '0) ? READ : DONE;
        end
      end
      READ: begin
        busy           = 1'b1;
        mem.memAddress = src_q + bytesCopied;
        state_nxt      = WRITE;
      end
      WRITE: begin
        busy               = 1'b1;
        mem.memAddress     = dst_q + bytesCopied;
        mem.memWriteData   = data_q;
        mem.memWriteEnable = 1'b1;
        state_nxt          = last_byte ? DONE : READ;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine against a 32-byte aliased memory model and a write scoreboard.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] srcAddr, dstAddr, length;
  logic        busy, done;
  logic [15:0] bytesCopied;

  mem_copy_engine_if bus ();

  mem_copy_engine dut (
    .clk(clk), .reset(reset), .start(start),
    .srcAddr(srcAddr), .dstAddr(dstAddr), .length(length),
    .mem(bus), .busy(busy), .done(done), .bytesCopied(bytesCopied)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Memory aliases on address[4:0]; image loaded in one edge via the load strobe.
  logic [7:0] mem   [32];
  logic [7:0] img   [32];
  logic [7:0] model [32];
  logic       load = 1'b0;

  assign bus.memReadData = mem[bus.memAddress[4:0]];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) mem[i] <= img[i];
    end else if (bus.memWriteEnable) begin
      mem[bus.memAddress[4:0]] <= bus.memWriteData;
    end
  end

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dat;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] rd_q[$];

  // Scoreboard: every write the engine presents is checked against the reference copy order.
  always @(negedge clk) begin
    if (bus.memWriteEnable === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_write: got addr=%h dat=%h, required no write", bus.memAddress, bus.memWriteData);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({bus.memAddress, bus.memWriteData} !== e)
          $display("FAIL sb_write: got addr=%h dat=%h, required addr=%h dat=%h",
                   bus.memAddress, bus.memWriteData, e.addr, e.dat);
        else
          passed++;
      end
    end else if (busy === 1'b1) begin
      rd_q.push_back(bus.memAddress);
    end
  end

  task automatic load_image();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = img[i];
    exp_q.delete();
    rd_q.delete();
  endtask

  // Reference forward copy, byte by byte in ascending order.
  task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    for (int i = 0; i < int'(l); i++) begin
      logic [15:0] sa, da;
      logic [7:0]  v;
      sa = s + 16'(i);
      da = d + 16'(i);
      v  = model[sa[4:0]];
      model[da[4:0]] = v;
      exp_q.push_back({da, v});
    end
  endtask

  // Issues a command at edge 0, then samples cycles 1..ncyc on the falling edge.
  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                          input int ncyc, input logic [63:0] pulse_mask, input int rst_cyc,
                          output logic [63:0] busy_map, output logic [63:0] we_map,
                          output logic [63:0] done_map);
    busy_map = '0; we_map = '0; done_map = '0;
    @(negedge clk);
    start = 1'b1; srcAddr = s; dstAddr = d; length = l;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      busy_map[c] = busy;
      we_map[c]   = bus.memWriteEnable;
      done_map[c] = done;
      reset = (c == rst_cyc);
      start = pulse_mask[c];
      if (pulse_mask[c]) begin
        srcAddr = 16'h0008; dstAddr = 16'h0018; length = 16'h0004;
      end else begin
        srcAddr = 16'($urandom); dstAddr = 16'($urandom); length = 16'($urandom);
      end
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; srcAddr = '0; dstAddr = '0; length = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    total++;
    if ({busy, done, bus.memWriteEnable} !== 3'b000)
      $display("FAIL reset_ctrl: got busy/done/we=%b, required 000", {busy, done, bus.memWriteEnable});
    else passed++;
    total++;
    if ({bus.memAddress, bus.memWriteData} !== 24'h0)
      $display("FAIL reset_bus: got addr=%h wdata=%h, required 0", bus.memAddress, bus.memWriteData);
    else passed++;
    total++;
    if (bytesCopied !== 16'h0) $display("FAIL reset_count: got %h, required 0", bytesCopied);
    else passed++;
  endtask

  task automatic test_basic();
    logic [63:0] bm, wm, dm;
    logic [7:0]  pat [4];
    pat = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) begin img[i] = pat[i]; img[16+i] = 8'hE0 + 8'(i); end
    load_image();
    model_copy(16'h0, 16'h10, 16'h4);
    run_copy(16'h0, 16'h10, 16'h4, 12, '0, 0, bm, wm, dm);
    total++;
    if (bm !== 64'h1FE) $display("FAIL basic_busy: got %h, required %h", bm, 64'h1FE); else passed++;
    total++;
    if (dm !== 64'h200) $display("FAIL basic_done: got %h, required %h", dm, 64'h200); else passed++;
    total++;
    if (wm !== 64'h154) $display("FAIL basic_we: got %h, required %h", wm, 64'h154); else passed++;
    total++;
    if (bytesCopied !== 16'h4) $display("FAIL basic_count: got %h, required 4", bytesCopied); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[16+i] !== pat[i]) $display("FAIL basic_mem%0d: got %h, required %h", 16+i, mem[16+i], pat[i]);
      else passed++;
      total++;
      if (rd_q.size() == 0) $display("FAIL basic_rd%0d: got none, required %h", i, i);
      else begin
        logic [15:0] ra;
        ra = rd_q.pop_front();
        if (ra !== 16'(i)) $display("FAIL basic_rd%0d: got %h, required %h", i, ra, i); else passed++;
      end
    end
    total++;
    if (exp_q.size() != 0) $display("FAIL basic_pending: got %0d, required 0", exp_q.size()); else passed++;
  endtask

  task automatic test_zero_length();
    logic [63:0] bm, wm, dm;
    int bad;
    load_image();
    run_copy(16'h5, 16'h10, 16'h0, 6, '0, 0, bm, wm, dm);
    total++;
    if (dm !== 64'h2) $display("FAIL zero_done: got %h, required %h", dm, 64'h2); else passed++;
    total++;
    if ({bm, wm} !== 128'h0) $display("FAIL zero_bus: got busy=%h we=%h, required 0", bm, wm); else passed++;
    total++;
    if (bytesCopied !== 16'h0) $display("FAIL zero_count: got %h, required 0", bytesCopied); else passed++;
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== img[i]) bad++;
    total++;
    if (bad != 0) $display("FAIL zero_mem: got %0d changed bytes, required 0", bad); else passed++;
  endtask

  task automatic test_start_ignored();
    logic [63:0] bm, wm, dm;
    for (int i = 0; i < 32; i++) img[i] = 8'h80 + 8'(i);
    load_image();
    model_copy(16'h0, 16'h10, 16'h4);
    // Extra start pulses land in READ (cycle 3) and in DONE (cycle 9).
    run_copy(16'h0, 16'h10, 16'h4, 14, 64'h208, 0, bm, wm, dm);
    total++;
    if (dm !== 64'h200) $display("FAIL ignore_done: got %h, required %h", dm, 64'h200); else passed++;
    total++;
    if (wm !== 64'h154) $display("FAIL ignore_we: got %h, required %h", wm, 64'h154); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[24+i] !== img[24+i] || mem[16+i] !== img[i])
        $display("FAIL ignore_mem%0d: got %h/%h, required %h/%h", i, mem[16+i], mem[24+i], img[i], img[24+i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] bm, wm, dm;
    for (int i = 0; i < 32; i++) img[i] = 8'h40 + 8'(i);
    load_image();
    model_copy(16'h0, 16'h10, 16'h4);
    run_copy(16'h0, 16'h10, 16'h4, 10, '0, 4, bm, wm, dm);
    total++;
    if (bm !== 64'h1E) $display("FAIL rstmid_busy: got %h, required %h", bm, 64'h1E); else passed++;
    total++;
    if (wm !== 64'h14 || dm !== 64'h0)
      $display("FAIL rstmid_we_done: got we=%h done=%h, required 14/0", wm, dm);
    else passed++;
    total++;
    if (mem[16] !== img[0] || mem[17] !== img[1])
      $display("FAIL rstmid_written: got %h %h, required %h %h", mem[16], mem[17], img[0], img[1]);
    else passed++;
    total++;
    if (mem[18] !== img[18] || mem[19] !== img[19])
      $display("FAIL rstmid_untouched: got %h %h, required %h %h", mem[18], mem[19], img[18], img[19]);
    else passed++;
    total++;
    if (exp_q.size() != 2 || bytesCopied !== 16'h0)
      $display("FAIL rstmid_abort: got pending=%0d count=%h, required 2/0", exp_q.size(), bytesCopied);
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_overlap();
    logic [63:0] bm, wm, dm;
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
    img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC; img[3] = 8'hDD;
    load_image();
    model_copy(16'h0, 16'h1, 16'h3);
    run_copy(16'h0, 16'h1, 16'h3, 10, '0, 0, bm, wm, dm);
    total++;
    if (dm !== 64'h80) $display("FAIL overlap_done: got %h, required %h", dm, 64'h80); else passed++;
    for (int i = 1; i <= 3; i++) begin
      total++;
      if (mem[i] !== 8'hAA) $display("FAIL overlap_mem%0d: got %h, required AA", i, mem[i]); else passed++;
    end
  endtask

  task automatic test_wrap();
    logic [63:0] bm, wm, dm;
    logic [15:0] ra;
    for (int i = 0; i < 32; i++) img[i] = 8'h20 + 8'(i);
    load_image();
    model_copy(16'hFFFF, 16'h4, 16'h2);
    run_copy(16'hFFFF, 16'h4, 16'h2, 8, '0, 0, bm, wm, dm);
    total++;
    if (rd_q.size() != 2) $display("FAIL wrap_reads: got %0d reads, required 2", rd_q.size());
    else begin
      ra = rd_q.pop_front();
      if (ra !== 16'hFFFF || rd_q[0] !== 16'h0000)
        $display("FAIL wrap_reads: got %h %h, required FFFF 0000", ra, rd_q[0]);
      else passed++;
    end
    total++;
    if (mem[4] !== img[31] || mem[5] !== img[0])
      $display("FAIL wrap_mem: got %h %h, required %h %h", mem[4], mem[5], img[31], img[0]);
    else passed++;
    total++;
    if (bytesCopied !== 16'h2) $display("FAIL wrap_count: got %h, required 2", bytesCopied); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_start_ignored();
    test_reset_mid();
    test_overlap();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
